// File: rtl/skolem_sweep_pkg.sv
// skolem_sweep_pkg: shared types and limits for the Skolem sweep sequencer.
// Holds the FSM state type/encodings, parameter limits and a drain-count helper.
package skolem_sweep_pkg;

    localparam int LAT_MAX  = 4;
    localparam int N_IN_MAX = 16;
    localparam int DW       = $clog2(LAT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Drain counter load value: counts LAT cycles down to zero.
    function automatic logic [DW-1:0] drain_init(input int lat);
        if (lat > 0)
            return DW'(lat - 1);
        return '0;
    endfunction

endpackage

// File: rtl/skolem_sweep_tag_pipe.sv
// skolem_sweep_tag_pipe: LAT-deep {vld,index} delay line aligning issued vectors
// with their responses. Ports: clk, rst_n, flush (sync clear), src_vld/src_idx in,
// dly_vld/dly_idx out. LAT=0 is a combinational passthrough.
module skolem_sweep_tag_pipe
    import skolem_sweep_pkg::*;
#(
    parameter int W   = 8,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         src_vld,
    input  logic [W-1:0] src_idx,
    output logic         dly_vld,
    output logic [W-1:0] dly_idx
);

    generate
        if (LAT == 0) begin : g_pass
            logic unused_sync;
            assign unused_sync = clk ^ rst_n ^ flush;
            assign dly_vld     = src_vld;
            assign dly_idx     = src_idx;
        end else begin : g_pipe
            logic [LAT-1:0] vld_q;
            logic [W-1:0]   idx_q [LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    for (int i = 0; i < LAT; i++)
                        idx_q[i] <= '0;
                end else if (flush) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= src_vld;
                    idx_q[0] <= src_idx;
                    for (int i = 1; i < LAT; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        idx_q[i] <= idx_q[i-1];
                    end
                end
            end

            assign dly_vld = vld_q[LAT-1];
            assign dly_idx = idx_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/skolem_sweep_ctrl.sv
// skolem_sweep_ctrl: exhaustive input sweep for a Skolem candidate. Issues every
// N_IN-bit vector once, aligns sat_any_i/sat_f_i responses LAT cycles later,
// counts violations and latches the lowest violating vector.
// Ports: clk, rst_n, start, abort, vec_o, vec_vld_o, sat_any_i, sat_f_i,
// busy, done, pass, err_cnt, cex_vld, first_cex.
// Build option SKOLEM_SWEEP_STOP_ON_CEX_EN: stop issuing at the first violation.
module skolem_sweep_ctrl
    import skolem_sweep_pkg::*;
#(
    parameter int N_IN = 8,
    parameter int LAT  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] vec_o,
    output logic            vec_vld_o,
    input  logic            sat_any_i,
    input  logic            sat_f_i,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic            cex_vld,
    output logic [N_IN-1:0] first_cex
);

    localparam logic [N_IN:0] CNT_ONE  = (N_IN+1)'(1);
    localparam logic [N_IN:0] CNT_LAST = {1'b0, {N_IN{1'b1}}};
    localparam logic [DW-1:0] DR_ONE   = DW'(1);
    localparam logic [DW-1:0] DR_INIT  = drain_init(LAT);
    // With no response latency there is nothing to drain.
    localparam state_t ISSUE_EXIT = (LAT == 0) ? ST_DONE : ST_DRAIN;

    state_t          state;
    logic [N_IN:0]   issue_cnt;
    logic [DW-1:0]   drain_cnt;
    logic            tag_vld;
    logic [N_IN-1:0] tag_idx;
    logic            viol;
    logic            last_issue;
    logic            stop_issue;
    logic            start_ok;
    logic [N_IN:0]   err_nxt;

    assign vec_o      = issue_cnt[N_IN-1:0];
    assign vec_vld_o  = (state == ST_ISSUE);
    assign busy       = (state != ST_IDLE);
    assign start_ok   = (state == ST_IDLE) && start && !abort;
    assign viol       = tag_vld & sat_any_i & ~sat_f_i;
    assign err_nxt    = err_cnt + {{N_IN{1'b0}}, viol};
    assign last_issue = (issue_cnt == CNT_LAST);

`ifdef SKOLEM_SWEEP_STOP_ON_CEX_EN
    assign stop_issue = last_issue | viol;
`else
    assign stop_issue = last_issue;
`endif

    skolem_sweep_tag_pipe #(
        .W   (N_IN),
        .LAT (LAT)
    ) u_tag (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (abort),
        .src_vld (vec_vld_o),
        .src_idx (vec_o),
        .dly_vld (tag_vld),
        .dly_idx (tag_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            issue_cnt <= '0;
            drain_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= ST_IDLE;
                issue_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state     <= ST_ISSUE;
                            issue_cnt <= '0;
                        end
                    end
                    ST_ISSUE: begin
                        issue_cnt <= issue_cnt + CNT_ONE;
                        if (stop_issue) begin
                            state     <= ISSUE_EXIT;
                            drain_cnt <= DR_INIT;
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_cnt == '0)
                            state <= ST_DONE;
                        else
                            drain_cnt <= drain_cnt - DR_ONE;
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt   <= '0;
            cex_vld   <= 1'b0;
            first_cex <= '0;
            pass      <= 1'b0;
        end else if (abort) begin
            pass <= 1'b0;
        end else if (start_ok) begin
            err_cnt   <= '0;
            cex_vld   <= 1'b0;
            first_cex <= '0;
            pass      <= 1'b0;
        end else begin
            if (viol) begin
                err_cnt <= err_nxt;
                // Vectors issue in ascending order, so the first hit is the lowest.
                if (!cex_vld) begin
                    cex_vld   <= 1'b1;
                    first_cex <= tag_idx;
                end
            end
            if (state == ST_DONE)
                pass <= (err_nxt == '0);
        end
    end

endmodule

// File: tb/tb_skolem_sweep_ctrl.sv
// tb_skolem_sweep_ctrl: runs three sweep controllers (LAT 0, 1, 4; N_IN=8) in
// lockstep against a per-vector response table and checks them with a sweep model.
module tb_skolem_sweep_ctrl;

    localparam int NI = 8;
    localparam int NV = 256;
    localparam int ND = 3;

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 4);
    endfunction

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 0: sat, 1: violation, 2: unsat (0,0), 3: unsat (0,1)
    int kind [NV];

    logic [NI-1:0] vec_a  [ND];
    logic          vv_a   [ND];
    logic          busy_a [ND];
    logic          done_a [ND];
    logic          pass_a [ND];
    logic          cexv_a [ND];
    logic [NI:0]   err_a  [ND];
    logic [NI-1:0] cex_a  [ND];

    generate
        for (genvar g = 0; g < ND; g++) begin : gi
            localparam int L = (g == 0) ? 0 : ((g == 1) ? 1 : 4);
            logic [NI-1:0] vec;
            logic          vv, sa, sf, busy, done, pass, cexv;
            logic [NI:0]   err;
            logic [NI-1:0] cex;
            logic [NI-1:0] h  [5];
            logic          hv [5];
            logic [NI-1:0] tidx;
            logic          tv;

            always @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < 5; i++) begin
                        h[i]  <= '0;
                        hv[i] <= 1'b0;
                    end
                end else begin
                    h[0]  <= vec;
                    hv[0] <= vv;
                    for (int i = 1; i < 5; i++) begin
                        h[i]  <= h[i-1];
                        hv[i] <= hv[i-1];
                    end
                end
            end

            if (L == 0) begin : g_l0
                assign tidx = vec;
                assign tv   = vv;
            end else begin : g_ln
                assign tidx = h[L-1];
                assign tv   = hv[L-1];
            end

            // With no live tag, present a violation pattern that must be ignored.
            always_comb begin
                sa = 1'b1;
                sf = 1'b0;
                if (tv) begin
                    case (kind[tidx])
                        1: begin sa = 1'b1; sf = 1'b0; end
                        2: begin sa = 1'b0; sf = 1'b0; end
                        3: begin sa = 1'b0; sf = 1'b1; end
                        default: begin sa = 1'b1; sf = 1'b1; end
                    endcase
                end
            end

            skolem_sweep_ctrl #(.N_IN(NI), .LAT(L)) dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .start     (start),
                .abort     (abort),
                .vec_o     (vec),
                .vec_vld_o (vv),
                .sat_any_i (sa),
                .sat_f_i   (sf),
                .busy      (busy),
                .done      (done),
                .pass      (pass),
                .err_cnt   (err),
                .cex_vld   (cexv),
                .first_cex (cex)
            );

            assign vec_a[g]  = vec;
            assign vv_a[g]   = vv;
            assign busy_a[g] = busy;
            assign done_a[g] = done;
            assign pass_a[g] = pass;
            assign cexv_a[g] = cexv;
            assign err_a[g]  = err;
            assign cex_a[g]  = cex;
        end
    endgenerate

    int sweep_id = 0;
    int seen_id  = 0;
    int t0       = 0;
    int da [ND] = '{default: -1};
    int vc [ND] = '{default: 0};
    int lv [ND] = '{default: -1};
    int dp [ND] = '{default: 0};

    always @(negedge clk) begin
        for (int i = 0; i < ND; i++) begin
            if (sweep_id != seen_id) begin
                da[i] <= -1;
                vc[i] <= 0;
                lv[i] <= -1;
                dp[i] <= 0;
            end else begin
                if (vv_a[i]) begin
                    vc[i] <= vc[i] + 1;
                    lv[i] <= int'(vec_a[i]);
                end
                if (done_a[i]) begin
                    dp[i] <= dp[i] + 1;
                    if (da[i] < 0)
                        da[i] <= cyc - t0;
                end
            end
        end
        seen_id <= sweep_id;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int i, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s lat=%0d: got %0d expected %0d", nm, lat_of(i), act, exp);
        end
    endtask

    task automatic set_kinds(input int noise, input int a, input int b);
        for (int v = 0; v < NV; v++) begin
            int r;
            r = int'($urandom_range(0, 2));
            kind[v] = (noise != 0) ? ((r == 0) ? 0 : r + 1) : 0;
        end
        if (a >= 0) kind[a] = 1;
        if (b >= 0) kind[b] = 1;
    endtask

    // Expected sweep extent and statistics from the response table.
    task automatic model(input int lat, output int last, output int err, output int first);
        first = -1;
        for (int v = 0; v < NV; v++) begin
            if (kind[v] == 1 && first < 0)
                first = v;
        end
        last = NV - 1;
`ifdef SKOLEM_SWEEP_STOP_ON_CEX_EN
        if (first >= 0 && first + lat < NV - 1)
            last = first + lat;
`endif
        err = 0;
        for (int v = 0; v <= last; v++) begin
            if (kind[v] == 1)
                err++;
        end
    endtask

    task automatic start_sweep();
        @(negedge clk);
        sweep_id++;
        @(negedge clk);
        start = 1'b1;
        t0    = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 700; k++) begin
            if (da[0] >= 0 && da[1] >= 0 && da[2] >= 0)
                break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_sweep(input int use_tbl, input int t_first, input int t_pass);
        for (int i = 0; i < ND; i++) begin
            int last, err, first, lat;
            lat = lat_of(i);
            model(lat, last, err, first);
            chk("done_at", i, da[i], last + lat + 2);
            chk("done_pulses", i, dp[i], 1);
            chk("vld_cycles", i, vc[i], last + 1);
            chk("last_vec", i, lv[i], last);
            chk("err_cnt", i, int'(err_a[i]), err);
            chk("cex_vld", i, int'(cexv_a[i]), (first >= 0) ? 1 : 0);
            if (first >= 0)
                chk("first_cex", i, int'(cex_a[i]), (use_tbl != 0) ? t_first : first);
            chk("pass", i, int'(pass_a[i]), (use_tbl != 0) ? t_pass : ((first < 0) ? 1 : 0));
            chk("busy_end", i, int'(busy_a[i]), 0);
        end
    endtask

    task automatic chk_idle(input string nm);
        for (int i = 0; i < ND; i++) begin
            chk({nm, "_busy"}, i, int'(busy_a[i]), 0);
            chk({nm, "_vld"}, i, int'(vv_a[i]), 0);
            chk({nm, "_done"}, i, int'(done_a[i]), 0);
            chk({nm, "_pass"}, i, int'(pass_a[i]), 0);
            chk({nm, "_err"}, i, int'(err_a[i]), 0);
            chk({nm, "_cexv"}, i, int'(cexv_a[i]), 0);
            chk({nm, "_cex"}, i, int'(cex_a[i]), 0);
            chk({nm, "_vec"}, i, int'(vec_a[i]), 0);
        end
    endtask

    typedef struct {
        int noise;
        int bad_a;
        int bad_b;
        int exp_first;
        int exp_pass;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{0, -1, -1, -1, 1};
        tbl[1] = '{0, 'h35, 'hC2, 'h35, 0};
        tbl[2] = '{1, -1, -1, -1, 1};
        tbl[3] = '{0, 'hFF, -1, 'hFF, 0};
        tbl[4] = '{0, 'h00, -1, 'h00, 0};
        tbl[5] = '{1, 'h10, -1, 'h10, 0};
        set_kinds(0, -1, -1);

        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle("post_reset");

        for (int t = 0; t < 6; t++) begin
            set_kinds(tbl[t].noise, tbl[t].bad_a, tbl[t].bad_b);
            start_sweep();
            wait_done();
            check_sweep(1, tbl[t].exp_first, tbl[t].exp_pass);
        end

        // Abort mid-sweep at vector 0x40; stats from the prior sweep are cleared by start.
        set_kinds(0, -1, -1);
        start_sweep();
        repeat (64) @(negedge clk);
        chk("abort_vec", 1, int'(vec_a[1]), 'h40);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int i = 0; i < ND; i++) begin
            chk("abort_busy", i, int'(busy_a[i]), 0);
            chk("abort_vld", i, int'(vv_a[i]), 0);
        end
        repeat (300) @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            chk("abort_no_done", i, dp[i], 0);
            chk("abort_pass", i, int'(pass_a[i]), 0);
            chk("abort_err", i, int'(err_a[i]), 0);
            chk("abort_cexv", i, int'(cexv_a[i]), 0);
        end

        // abort and start in the same cycle: abort wins.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < ND; i++)
            chk("abort_over_start", i, int'(busy_a[i]), 0);

        set_kinds(0, 'h35, -1);
        start_sweep();
        wait_done();
        check_sweep(0, 0, 0);

        // Reset asserted mid-sweep returns everything to reset values at once.
        set_kinds(0, 5, -1);
        start_sweep();
        repeat (30) @(negedge clk);
        for (int i = 0; i < ND; i++)
            chk("pre_reset_err", i, int'(err_a[i]), 1);
        rst_n = 1'b0;
        #1;
        chk_idle("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 6; r++) begin
            int nb;
            set_kinds(1, -1, -1);
            nb = int'($urandom_range(0, 3));
            for (int k = 0; k < nb; k++)
                kind[$urandom_range(0, NV - 1)] = 1;
            start_sweep();
            wait_done();
            check_sweep(0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
